cpu_ctrl: RTL

Instruction sequencer for the 8-bit accumulator CPU. It fetches two-byte instructions from memory and drives the ALU's opcode and operand inputs. It then writes the ALU result back into the accumulator and performs memory stores, jumps and conditional skips. The block sits between the memory bus and the ALU: it is the issuing side of the ALU opcode/operand interface.

---
 rtl/cpu_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 8-bit accumulator CPU: fetches two-byte
// instructions, issues ALU operations, writes back, stores, jumps and skips.
module cpu_ctrl (
   input  logic       clk,
   input  logic       rst_clk,
   output logic [7:0] mem_addr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready,
   output logic [4:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_data,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   output logic [7:0] acc_out,
   output logic [7:0] pc_out,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH0 = 3'd1,
      S_FETCH1 = 3'd2,
      S_READ   = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5,
      S_STORE  = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [4:0] OP_HLT = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_AND = 5'b00011;
   localparam logic [4:0] OP_OR  = 5'b00100;
   localparam logic [4:0] OP_LDA = 5'b00101;
   localparam logic [4:0] OP_STO = 5'b00110;
   localparam logic [4:0] OP_JMP = 5'b00111;
   localparam logic [4:0] OP_XOR = 5'b01000;
   localparam logic [4:0] OP_SKZ = 5'b01001;

   state_t     state_q;
   logic [7:0] pc_q, acc_q, oper_q, mdr_q, addr_q;
   logic [4:0] ir_q, op_q;
   logic       rd_q, wr_q, halt_q;

   state_t     state_f1_d;
   logic [7:0] pc_f1_d;

   // Branch decision taken when the operand byte arrives in FETCH1
   always_comb begin
      pc_f1_d    = pc_q + 8'd1;
      state_f1_d = S_FETCH0;
      case (ir_q)
         OP_JMP: pc_f1_d = mem_rdata;
         OP_SKZ: pc_f1_d = alu_zero ? (pc_q + 8'd3) : (pc_q + 8'd1);
         OP_STO: state_f1_d = S_STORE;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDA, OP_XOR: state_f1_d = S_READ;
         default: state_f1_d = S_FETCH0;
      endcase
   end

   // Sequencer FSM; bus and ALU strobes are registered for the state being entered
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         state_q <= S_IDLE;
         pc_q    <= 8'h00;
         acc_q   <= 8'h00;
         ir_q    <= 5'd0;
         oper_q  <= 8'h00;
         mdr_q   <= 8'h00;
         addr_q  <= 8'h00;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         op_q    <= 5'd0;
         halt_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH0;
               rd_q    <= 1'b1;
               addr_q  <= pc_q;
            end
            S_FETCH0: begin
               if (mem_ready) begin
                  ir_q <= mem_rdata[4:0];
                  pc_q <= pc_q + 8'd1;
                  if (mem_rdata[4:0] == OP_HLT) begin
                     state_q <= S_HALT;
                     rd_q    <= 1'b0;
                     halt_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH1;
                     addr_q  <= pc_q + 8'd1;
                  end
               end
            end
            S_FETCH1: begin
               if (mem_ready) begin
                  oper_q  <= mem_rdata;
                  pc_q    <= pc_f1_d;
                  state_q <= state_f1_d;
                  case (state_f1_d)
                     S_READ: addr_q <= mem_rdata;
                     S_STORE: begin
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b1;
                        addr_q <= mem_rdata;
                     end
                     default: addr_q <= pc_f1_d;
                  endcase
               end
            end
            S_READ: begin
               if (mem_ready) begin
                  mdr_q   <= mem_rdata;
                  state_q <= S_EXEC;
                  rd_q    <= 1'b0;
                  op_q    <= ir_q;
               end
            end
            S_EXEC: begin
               state_q <= S_WB;
               op_q    <= 5'd0;
            end
            S_WB: begin
               acc_q   <= alu_result;
               state_q <= S_FETCH0;
               rd_q    <= 1'b1;
               addr_q  <= pc_q;
            end
            S_STORE: begin
               if (mem_ready) begin
                  state_q <= S_FETCH0;
                  wr_q    <= 1'b0;
                  rd_q    <= 1'b1;
                  addr_q  <= pc_q;
               end
            end
            S_HALT: state_q <= S_HALT;
            default: begin
               state_q <= S_IDLE;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               op_q    <= 5'd0;
            end
         endcase
      end
   end

   assign mem_addr  = addr_q;
   assign mem_rd    = rd_q;
   assign mem_wr    = wr_q;
   assign mem_wdata = acc_q;
   assign alu_op    = op_q;
   assign alu_a     = acc_q;
   assign alu_data  = mdr_q;
   assign acc_out   = acc_q;
   assign pc_out    = pc_q;
   assign halted    = halt_q;

endmodule
